// File: rtl/iot_game_pkg.sv
// Shared types and widths for the rhythm-game control blocks.
// Holds the sequencer state encoding plus score/time/countdown widths.
package iot_game_pkg;

    localparam int SCORE_W = 11;
    localparam int TIME_W  = 10;
    localparam int CD_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_RESULT    = 3'd4
    } game_state_e;

    // A new round may only be launched from a resting state.
    function automatic logic is_startable(input game_state_e s);
        return (s == ST_IDLE) || (s == ST_RESULT);
    endfunction

endpackage

// File: rtl/game_sequencer_tick_downcounter.sv
// Loadable down-counter that steps on an enable pulse and saturates at zero.
// Reports zero and "one step left" flags for the owning FSM.
module tick_downcounter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == {W{1'b0}});
    assign last_o  = (count_q == W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer: idle -> countdown -> play/pause -> result, with score latch.
// Optional high-score tracking is built only when GAME_SEQUENCER_HISCORE_EN is defined.
module game_sequencer
    import iot_game_pkg::*;
#(
    parameter int SONG_LEN        = 600,
    parameter int COUNTDOWN_TICKS = 30
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic [TIME_W-1:0]  counter10h,
    input  logic [SCORE_W-1:0] score,
    output logic               game_run,
    output logic               game_clear,
    output logic [2:0]         state,
    output logic [CD_W-1:0]    cd_remain,
    output logic [SCORE_W-1:0] final_score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record
);

    game_state_e        state_q, state_d;
    logic               game_clear_q, game_clear_d;
    logic [SCORE_W-1:0] final_score_q, final_score_d;

    logic               cd_load_s;
    logic [CD_W-1:0]    cd_load_val_s;
    logic               cd_dec_s;
    logic               cd_zero_s;
    logic               cd_last_s;
    logic               song_end_s;
    logic               latch_s;

    assign song_end_s = (counter10h >= TIME_W'(SONG_LEN));

    tick_downcounter #(
        .W (CD_W)
    ) u_countdown (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (cd_load_s),
        .load_val_i (cd_load_val_s),
        .dec_i      (cd_dec_s),
        .count_o    (cd_remain),
        .zero_o     (cd_zero_s),
        .last_o     (cd_last_s)
    );

    // Next-state and control decode; abort > song end > start > pause.
    always_comb begin
        state_d       = state_q;
        game_clear_d  = 1'b0;
        cd_load_s     = 1'b0;
        cd_load_val_s = {CD_W{1'b0}};
        cd_dec_s      = 1'b0;
        latch_s       = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cd_load_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_RESULT: begin
                    if (start && is_startable(state_q)) begin
                        state_d       = ST_COUNTDOWN;
                        game_clear_d  = 1'b1;
                        cd_load_s     = 1'b1;
                        cd_load_val_s = CD_W'(COUNTDOWN_TICKS);
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_COUNTDOWN: begin
                    if (tick) begin
                        cd_dec_s = 1'b1;
                        // Zero here only if the counter was disturbed; leave rather than stall.
                        if (cd_last_s || cd_zero_s) begin
                            state_d = ST_PLAY;
                        end else begin
                            state_d = ST_COUNTDOWN;
                        end
                    end else begin
                        state_d = ST_COUNTDOWN;
                    end
                end
                ST_PLAY: begin
                    if (song_end_s) begin
                        state_d = ST_RESULT;
                        latch_s = 1'b1;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_d = ST_PLAY;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Final score only changes when a round completes normally.
    always_comb begin
        final_score_d = final_score_q;
        if (latch_s) begin
            final_score_d = score;
        end else begin
            final_score_d = final_score_q;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            game_clear_q  <= 1'b0;
            final_score_q <= {SCORE_W{1'b0}};
        end else begin
            state_q       <= state_d;
            game_clear_q  <= game_clear_d;
            final_score_q <= final_score_d;
        end
    end

`ifdef GAME_SEQUENCER_HISCORE_EN
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic               new_record_q, new_record_d;

    // Record check is strict: tying the best score is not a new record.
    always_comb begin
        high_score_d = high_score_q;
        new_record_d = new_record_q;
        if (latch_s) begin
            new_record_d = (score > high_score_q);
            if (score > high_score_q) begin
                high_score_d = score;
            end else begin
                high_score_d = high_score_q;
            end
        end else begin
            new_record_d = new_record_q;
        end
    end

    // High-score registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high_score_q <= {SCORE_W{1'b0}};
            new_record_q <= 1'b0;
        end else begin
            high_score_q <= high_score_d;
            new_record_q <= new_record_d;
        end
    end

    assign high_score = high_score_q;
    assign new_record = new_record_q;
`else
    assign high_score = {SCORE_W{1'b0}};
    assign new_record = 1'b0;
`endif

    assign state       = state_q;
    assign game_run    = (state_q == ST_PLAY);
    assign game_clear  = game_clear_q;
    assign final_score = final_score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed plus randomized bench for game_sequencer against a rule-level reference model.
module tb_game_sequencer;

    localparam int SONG = 20;
    localparam int CDT  = 3;
`ifdef GAME_SEQUENCER_HISCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        tick, start, pause, abort;
    logic [9:0]  counter10h;
    logic [10:0] score;
    logic        game_run, game_clear, new_record;
    logic [2:0]  state;
    logic [7:0]  cd_remain;
    logic [10:0] final_score, high_score;

    int checks   = 0;
    int failures = 0;

    int m_state, m_cd, m_final, m_high, m_newrec, m_clear;

    game_sequencer #(
        .SONG_LEN        (SONG),
        .COUNTDOWN_TICKS (CDT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .counter10h  (counter10h),
        .score       (score),
        .game_run    (game_run),
        .game_clear  (game_clear),
        .state       (state),
        .cd_remain   (cd_remain),
        .final_score (final_score),
        .high_score  (high_score),
        .new_record  (new_record)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cd = 0; m_final = 0; m_high = 0; m_newrec = 0; m_clear = 0;
    endtask

    // Rules: abort beats song end beats start beats pause.
    task automatic model_step(input bit st, pa, ab, tk, input int cnt, sc);
        m_clear = 0;
        if (ab && m_state != 0) begin
            m_state = 0;
            m_cd    = 0;
        end else if ((m_state == 0 || m_state == 4) && st) begin
            m_state = 1;
            m_cd    = CDT;
            m_clear = 1;
        end else if (m_state == 1 && tk) begin
            if (m_cd > 0) m_cd = m_cd - 1;
            if (m_cd == 0) m_state = 2;
        end else if (m_state == 2 && cnt >= SONG) begin
            m_state = 4;
            m_final = sc;
            if (HS) begin
                m_newrec = (sc > m_high) ? 1 : 0;
                if (sc > m_high) m_high = sc;
            end
        end else if ((m_state == 2 || m_state == 3) && pa) begin
            m_state = (m_state == 2) ? 3 : 2;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".state"},       state,       m_state);
        chk({ctx, ".game_run"},    game_run,    (m_state == 2) ? 1 : 0);
        chk({ctx, ".game_clear"},  game_clear,  m_clear);
        chk({ctx, ".cd_remain"},   cd_remain,   m_cd);
        chk({ctx, ".final_score"}, final_score, m_final);
        chk({ctx, ".high_score"},  high_score,  m_high);
        chk({ctx, ".new_record"},  new_record,  m_newrec);
    endtask

    task automatic step(input string ctx, input bit st, pa, ab, tk, input int cnt, sc);
        start = st; pause = pa; abort = ab; tick = tk;
        counter10h = 10'(cnt);
        score      = 11'(sc);
        model_step(st, pa, ab, tk, cnt, sc);
        @(posedge clock);
        #1;
        start = 1'b0; pause = 1'b0; abort = 1'b0; tick = 1'b0;
        check_all(ctx);
    endtask

    task automatic run_countdown(input string ctx);
        step({ctx, ".start"}, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < CDT; i++) step({ctx, ".tick"}, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        counter10h = 10'd0; score = 11'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all("reset");
        reset = 1'b0;
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // First round: countdown, start ignored mid-countdown, song end with 123.
        step("r1.start", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("r1.clear_hi", game_clear, 1);
        chk("r1.cd3", cd_remain, 3);
        step("r1.ignore_start", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("r1.clear_lo", game_clear, 0);
        step("r1.t1", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("r1.cd2", cd_remain, 2);
        step("r1.t2", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        step("r1.t3", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("r1.play", state, 2);
        chk("r1.run", game_run, 1);
        step("r1.mid", 1'b0, 1'b0, 1'b0, 1'b1, 19, 50);
        step("r1.end", 1'b0, 1'b0, 1'b0, 1'b0, 20, 123);
        chk("r1.final", final_score, 123);
        chk("r1.high", high_score, HS ? 123 : 0);
        chk("r1.newrec", new_record, HS ? 1 : 0);
        step("r1.hold", 1'b0, 1'b1, 1'b0, 1'b0, 25, 7);

        // Equal score is not a record; then a higher one is.
        run_countdown("r2");
        step("r2.end", 1'b0, 1'b0, 1'b0, 1'b0, 30, 123);
        chk("r2.newrec", new_record, 0);
        chk("r2.high", high_score, HS ? 123 : 0);

        // Pause/resume, then pause coinciding with song end.
        run_countdown("r3");
        step("r3.pause", 1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
        chk("r3.paused_run", game_run, 0);
        step("r3.pause_songlen", 1'b0, 1'b0, 1'b0, 1'b0, 20, 99);
        step("r3.resume", 1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
        step("r3.pause_end", 1'b0, 1'b1, 1'b0, 1'b0, 20, 200);
        chk("r3.result", state, 4);
        chk("r3.high", high_score, HS ? 200 : 0);

        // Abort with start in PLAY.
        run_countdown("r4");
        step("r4.abort_start", 1'b1, 1'b0, 1'b1, 1'b0, 20, 999);
        chk("r4.final_kept", final_score, 200);

        // Asynchronous reset mid-countdown.
        step("r5.start", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step("r5.t1", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("r6.idle", 1'b0, 1'b1, 1'b1, 1'b1, 25, 5);
        run_countdown("r6");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step("rand",
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 21)),
                 int'($urandom_range(0, 2047)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
